post_proc_reducer: RTL and testbench

//  Parametrised successor of the fixed 6->1 post-processing reducer. Collapses N_CH signed pool-layer

---
 rtl/post_proc_reducer.sv | 178 +++++++++++++++++
 tb/tb_post_proc_reducer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/post_proc_reducer.sv
// post_proc_reducer: reduces N_CH signed features per beat to one OUT_W-bit value.
// Per-beat mode selects sum, alternating sum or signed maximum. A pipelined tree
// feeds a shift/saturate stage and a first-word-fall-through output FIFO. The
// registered o_ready credit counts FIFO entries plus beats still in the pipeline,
// so the FIFO can never be written while full.
module post_proc_reducer #(
   parameter int N_CH       = 6,
   parameter int DATA_W     = 8,
   parameter int OUT_W      = 8,
   parameter int SHIFT      = 0,
   parameter int SAT        = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_valid,
   input  logic [N_CH*DATA_W-1:0]   i_features,
   input  logic [1:0]               i_mode,
   output logic                     o_ready,
   output logic [OUT_W-1:0]         o_data,
   output logic                     o_valid,
   input  logic                     i_out_ready,
   input  logic                     i_clr_ovf,
   output logic                     o_overflow
);

   localparam int S     = $clog2(N_CH);
   localparam int ACC_W = DATA_W + S;
   localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic signed [EXT_W-1:0] MAXV = (EXT_W'(1) <<< (OUT_W - 1)) - EXT_W'(1);
   localparam logic signed [EXT_W-1:0] MINV = ~MAXV;

   // Number of live nodes at tree level l (level 0 holds the channels).
   function automatic int node_cnt(input int l);
      return (N_CH + (1 << l) - 1) >> l;
   endfunction

   function automatic logic [ACC_W-1:0] combine(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b,
                                                input logic [1:0]       m);
      if (m == 2'd2) return ($signed(a) > $signed(b)) ? a : b;
      return a + b;
   endfunction

   logic             accept;
   logic [S:0]       vld;
   logic [S-1:0][1:0] mode_q;

   assign accept = i_valid && o_ready;

   // Valid and mode travel alongside the tree levels; bubbles are just zero valids.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld    <= '0;
         mode_q <= '0;
      end else begin
         vld       <= {vld[S-1:0], accept};
         mode_q[0] <= i_mode;
         for (int l = 1; l < S; l++) mode_q[l] <= mode_q[l-1];
      end
   end

   // Tree levels: level 0 registers sign-extended inputs (odd channels negated in
   // ALT mode); each later level pairs adjacent nodes, passing an unpaired node on.
   for (genvar l = 0; l <= S; l++) begin : g_lvl
      localparam int NN = node_cnt(l);
      logic [NN-1:0][ACC_W-1:0] node;
      logic [NN-1:0][ACC_W-1:0] nxt;

      for (genvar j = 0; j < NN; j++) begin : g_node
         if (l == 0) begin : g_src
            logic [ACC_W-1:0] sx;
            assign sx     = ACC_W'($signed(i_features[j*DATA_W +: DATA_W]));
            assign nxt[j] = (i_mode == 2'd1 && (j % 2 == 1)) ? -sx : sx;
         end else if (2*j + 1 < node_cnt(l - 1)) begin : g_pair
            assign nxt[j] = combine(g_lvl[l-1].node[2*j], g_lvl[l-1].node[2*j+1], mode_q[l-1]);
         end else begin : g_pass
            assign nxt[j] = g_lvl[l-1].node[2*j];
         end
      end

      // Level register.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) node <= '0;
         else          node <= nxt;
      end
   end

   logic signed [ACC_W-1:0] scaled;
   logic signed [EXT_W-1:0] ext;
   logic [OUT_W-1:0]        sat_val;
   logic [OUT_W-1:0]        sat_data;
   logic                    sat_vld;

   assign scaled = $signed(g_lvl[S].node[0]) >>> SHIFT;
   assign ext    = EXT_W'(scaled);

   // Clamp to the signed OUT_W range, or wrap by keeping the low bits.
   always_comb begin
      sat_val = ext[OUT_W-1:0];
      if (SAT != 0) begin
         if (ext > MAXV)      sat_val = MAXV[OUT_W-1:0];
         else if (ext < MINV) sat_val = MINV[OUT_W-1:0];
      end
   end

   // Shift/saturate register, last stage before the FIFO.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sat_vld  <= 1'b0;
         sat_data <= '0;
      end else begin
         sat_vld  <= vld[S];
         sat_data <= sat_val;
      end
   end

   logic [OUT_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count, count_next;
   logic [OUT_W-1:0] last_q;
   logic             wr, rd, rdy_next;

   assign wr      = sat_vld;
   assign o_valid = (count != '0);
   assign rd      = o_valid && i_out_ready;
   // When empty, keep showing the last word that left the FIFO (zero after reset).
   assign o_data  = o_valid ? mem[rd_ptr] : last_q;

   // FIFO occupancy after this edge.
   always_comb begin
      count_next = count;
      if (wr && !rd)      count_next = count + 1'b1;
      else if (!wr && rd) count_next = count - 1'b1;
   end

   assign rdy_next = (int'(count_next) + int'(accept) + $countones(vld)) < FIFO_DEPTH;

   // FIFO storage needs no reset; count gates visibility.
   always_ff @(posedge i_clk) begin
      if (wr) mem[wr_ptr] <= sat_data;
   end

   // FIFO pointers, occupancy, held output word and registered credit.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         last_q  <= '0;
         o_ready <= 1'b0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (rd) begin
            rd_ptr <= rd_ptr + 1'b1;
            last_q <= mem[rd_ptr];
         end
         count   <= count_next;
         o_ready <= rdy_next;
      end
   end

   // Sticky drop flag; a drop in the same cycle as a clear wins.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                o_overflow <= 1'b0;
      else if (i_valid && !o_ready) o_overflow <= 1'b1;
      else if (i_clr_ovf)          o_overflow <= 1'b0;
   end

   // The credit scheme must make a write into a full FIFO impossible.
   always_ff @(posedge i_clk) begin
      if (i_rst_n) assert (!(wr && !rd && count == CNT_W'(FIFO_DEPTH)));
   end

endmodule

// File: tb/tb_post_proc_reducer.sv
// Directed bench for post_proc_reducer: a default instance plus wrap (SAT=0) and
// shift (SHIFT=2) variants sharing the same stimulus.
module tb_post_proc_reducer;
   localparam int N_CH = 6, DATA_W = 8, OUT_W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst_n = 1'b1;
   logic                   i_valid, out_ready, clr_ovf;
   logic [N_CH*DATA_W-1:0] feat;
   logic [1:0]             mode;
   logic                   rdy, vld, ovf;
   logic [OUT_W-1:0]       data;
   logic                   rdy_w, vld_w, ovf_w;
   logic [OUT_W-1:0]       data_w;
   logic                   rdy_s, vld_s, ovf_s;
   logic [OUT_W-1:0]       data_s;

   int checks = 0;
   int errors = 0;

   post_proc_reducer u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_features(feat), .i_mode(mode),
      .o_ready(rdy), .o_data(data), .o_valid(vld), .i_out_ready(out_ready),
      .i_clr_ovf(clr_ovf), .o_overflow(ovf));

   post_proc_reducer #(.SAT(0)) u_wrap (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_features(feat), .i_mode(mode),
      .o_ready(rdy_w), .o_data(data_w), .o_valid(vld_w), .i_out_ready(out_ready),
      .i_clr_ovf(clr_ovf), .o_overflow(ovf_w));

   post_proc_reducer #(.SHIFT(2)) u_shift (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_features(feat), .i_mode(mode),
      .o_ready(rdy_s), .o_data(data_s), .o_valid(vld_s), .i_out_ready(out_ready),
      .i_clr_ovf(clr_ovf), .o_overflow(ovf_s));

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N_CH*DATA_W-1:0] pack(input int a, input int b, input int c,
                                                   input int d, input int e, input int f);
      return {8'(f), 8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   function automatic logic [N_CH*DATA_W-1:0] pack_all(input int v);
      return pack(v, v, v, v, v, v);
   endfunction

   // One beat into an empty pipeline with i_out_ready=1; checks latency and all three results.
   task automatic run_beat(input string tag, input logic [N_CH*DATA_W-1:0] f, input logic [1:0] m,
                           input int exp_main, input int exp_wrap, input int exp_shift);
      int n;
      feat = f; mode = m; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      n = 0;
      while (!vld && n < 12) begin
         tick();
         n++;
      end
      check({tag, " latency"}, n, 5);
      check({tag, " main"},  int'($signed(data)),   exp_main);
      check({tag, " wrap"},  int'($signed(data_w)), exp_wrap);
      check({tag, " shift"}, int'($signed(data_s)), exp_shift);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N_CH*DATA_W-1:0] set1;
      int bb_mode[4] = '{0, 1, 2, 0};
      int bb_exp[4]  = '{58, 24, 30, 58};
      int got[$];
      int n, sent, nv;
      logic took;

      i_valid = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0; feat = '0; mode = 2'd0;
      set1 = pack(10, 20, 30, -5, 1, 2);

      // Reset state
      #1 rst_n = 1'b0;
      #11;
      check("rst o_valid", vld, 0);
      check("rst o_data", int'($signed(data)), 0);
      check("rst o_overflow", ovf, 0);
      check("rst o_ready", rdy, 0);
      rst_n = 1'b1;
      tick();
      check("ready after release", rdy, 1);

      // Single beats: modes, saturation, wrap, shift, odd-node passthrough
      run_beat("sum",          set1, 2'd0, 58, 58, 14);
      run_beat("sum all 100",  pack_all(100), 2'd0, 127, 88, 127);
      run_beat("sum all -128", pack_all(-128), 2'd0, -128, 0, -128);
      run_beat("alt",          set1, 2'd1, 24, 24, 6);
      run_beat("max",          set1, 2'd2, 30, 30, 7);
      run_beat("max negative", pack(-5, -3, -100, -7, -9, -4), 2'd2, -3, -3, -1);
      run_beat("max last ch",  pack(1, 2, 3, 4, 5, 50), 2'd2, 50, 50, 12);
      run_beat("mode3 sum",    set1, 2'd3, 58, 58, 14);
      run_beat("alt extremes", pack(-128, 127, -128, 127, -128, 127), 2'd1, -128, 3, -128);

      // Back-to-back beats, consecutive results
      for (int i = 0; i < 4; i++) begin
         feat = set1; mode = 2'(bb_mode[i]); i_valid = 1'b1;
         tick();
      end
      i_valid = 1'b0;
      n = 0;
      while (!vld && n < 12) begin
         tick();
         n++;
      end
      check("b2b first latency", n, 2);
      for (int i = 0; i < 4; i++) begin
         check("b2b valid", vld, 1);
         check("b2b data", int'($signed(data)), bb_exp[i]);
         tick();
      end
      check("b2b empty after", vld, 0);

      // Backpressure: fill with i_out_ready=0 honouring o_ready
      out_ready = 1'b0; sent = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         took = (sent < 10) && rdy;
         i_valid = took;
         feat = pack_all(sent + 1);
         tick();
         if (took) sent++;
      end
      i_valid = 1'b0;
      check("credits used", sent, 4);
      check("ready low when full", rdy, 0);
      check("head valid held", vld, 1);
      check("head data held", int'($signed(data)), 6);
      check("no overflow when honoured", ovf, 0);

      // Release: drain the 4, then the stream resumes in order
      out_ready = 1'b1; got.delete();
      for (int cyc = 0; cyc < 80 && got.size() < 10; cyc++) begin
         if (vld) got.push_back(int'($signed(data)));
         took = (sent < 10) && rdy;
         i_valid = took;
         feat = pack_all(sent + 1);
         tick();
         if (took) sent++;
      end
      i_valid = 1'b0;
      check("stream count", got.size(), 10);
      for (int i = 0; i < 10; i++)
         check("stream order", (i < got.size()) ? got[i] : -999, 6 * (i + 1));
      repeat (8) tick();

      // Drop while full sets overflow; clear; clear+drop keeps it set
      out_ready = 1'b0; sent = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         took = (sent < 4) && rdy;
         i_valid = took;
         feat = pack_all(sent + 1);
         tick();
         if (took) sent++;
      end
      check("full before drop", rdy, 0);
      feat = pack_all(7); i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      check("overflow set", ovf, 1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("overflow cleared", ovf, 0);
      i_valid = 1'b1; clr_ovf = 1'b1;
      tick();
      i_valid = 1'b0; clr_ovf = 1'b0;
      check("drop wins over clear", ovf, 1);
      out_ready = 1'b1; got.delete();
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (vld) got.push_back(int'($signed(data)));
         tick();
      end
      check("dropped beats absent count", got.size(), 4);
      for (int i = 0; i < 4; i++)
         check("kept beats order", (i < got.size()) ? got[i] : -999, 6 * (i + 1));

      // Reset with beats buffered and in flight
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         feat = pack_all(i + 1); i_valid = 1'b1;
         tick();
      end
      i_valid = 1'b0;
      repeat (7) tick();
      for (int i = 0; i < 2; i++) begin
         feat = pack_all(i + 3); i_valid = 1'b1;
         tick();
      end
      i_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async rst o_valid", vld, 0);
      check("async rst o_ready", rdy, 0);
      check("async rst o_data", int'($signed(data)), 0);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      check("ready after mid reset", rdy, 1);
      nv = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (vld) nv++;
         tick();
      end
      check("no stale output", nv, 0);
      run_beat("after reset", set1, 2'd1, 24, 24, 6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
